// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: buffered PIM result entry and starvation FSM states.
package wb_arbiter_pkg;

    localparam int WB_XLEN               = 32;
    localparam int WB_FIFO_DEPTH_DEFAULT = 4;
    localparam int WB_MAX_WAIT_DEFAULT   = 8;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        FORCE   = 2'd2
    } starv_state_e;

    // x0 is hardwired to zero, so a destination of 0 never produces a write.
    function automatic logic rd_writes(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering out-of-order PIM results until a writeback slot is free.
module wb_result_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  wb_entry_t     i_entry,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign o_full  = (count_q == CNT_FULL);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // A push while full is only legal when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// MEM->WB register that merges pipeline results with buffered PIM results and
// keeps a pending-rd scoreboard for RAW/WAW/starvation stalls.
//
//  state   | meaning
//  IDLE    | FIFO empty or popped this cycle
//  WAITING | FIFO holds results but pipeline keeps taking the WB slot
//  FORCE   | waited MAX_WAIT cycles; stall front end until a pop happens
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT,
    parameter int MAX_WAIT   = WB_MAX_WAIT_DEFAULT,
    parameter int XLEN       = WB_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mem_reg_write,
    input  logic [4:0]      i_mem_rd,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_pim_issue,
    input  logic [4:0]      i_pim_issue_rd,
    input  logic            i_pim_valid,
    input  logic [4:0]      i_pim_rd,
    input  logic [XLEN-1:0] i_pim_data,
    output logic            o_pim_ready,
    input  logic [4:0]      i_dec_rs1,
    input  logic [4:0]      i_dec_rs2,
    input  logic            i_dec_rs1_used,
    input  logic            i_dec_rs2_used,
    output logic            o_stall,
    output logic            o_wb_reg_write,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_ONE   = CW'(1);
    localparam logic [AW:0]   CNT_MAX    = (AW+1)'(FIFO_DEPTH);

    wb_entry_t     push_entry;
    wb_entry_t     fifo_head;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;
    logic          mem_slot, pop, push;

    logic [31:0]   pending_q, pending_d;
    logic          raw_hit, waw_hit, starved, issue_fire;

    starv_state_e  state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    // Pipeline always owns the slot when it really writes; the FIFO fills the gaps.
    assign mem_slot    = i_mem_reg_write && rd_writes(i_mem_rd);
    assign pop         = !fifo_empty && !mem_slot;
    assign o_pim_ready = !fifo_full || pop;
    assign push        = i_pim_valid && o_pim_ready;

    assign push_entry.rd   = i_pim_rd;
    assign push_entry.data = i_pim_data;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_entry (push_entry),
        .i_pop   (pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign raw_hit = (i_dec_rs1_used && rd_writes(i_dec_rs1) && pending_q[i_dec_rs1])
                  || (i_dec_rs2_used && rd_writes(i_dec_rs2) && pending_q[i_dec_rs2]);
    assign waw_hit = i_pim_issue && rd_writes(i_pim_issue_rd) && pending_q[i_pim_issue_rd];
    assign starved = (state_q == FORCE);
    assign o_stall = raw_hit || waw_hit || starved;

    // The issue input is a request; it only takes effect when decode is not held.
    assign issue_fire = i_pim_issue && !o_stall && rd_writes(i_pim_issue_rd);

    always_comb begin
        pending_d = pending_q;
        if (pop)        pending_d[fifo_head.rd]    = 1'b0;
        if (issue_fire) pending_d[i_pim_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;
        if (pop || fifo_empty) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !pop)
                    state_d = (wait_cnt_d == WAIT_LIMIT) ? FORCE : WAITING;
            end
            WAITING: begin
                if (pop || fifo_empty)
                    state_d = IDLE;
                else if (wait_cnt_d == WAIT_LIMIT)
                    state_d = FORCE;
            end
            FORCE: begin
                if (pop || fifo_empty)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (mem_slot) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = i_mem_rd;
            wb_data_d = i_mem_data;
        end else if (pop) begin
            wb_we_d   = rd_writes(fifo_head.rd);
            wb_rd_d   = fifo_head.rd;
            wb_data_d = fifo_head.data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q  <= '0;
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign o_wb_reg_write = wb_we_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_data      = wb_data_q;

    a_fifo_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        fifo_count <= CNT_MAX);

endmodule
